// File: rtl/pp_bank_scheduler.sv
// Two-bank ping-pong buffer scheduler: writer steering, oldest-first reader launch.
// Optional watchdog on stuck reads: define SCHED_WATCHDOG_EN (adds wd_err).
module pp_bank_scheduler #(
    parameter int PKT_LEN = 188,
    parameter int CE_DIV  = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_done,
    output logic             wr_bank,
    output logic             wr_stall,
    output logic             rd_start,
    output logic             rd_bank,
    input  logic             rd_done,
    output logic [1:0]       bank_full,
    output logic             busy,
    output logic             overflow,
    output logic [CNT_W-1:0] pkt_cnt
`ifdef SCHED_WATCHDOG_EN
    ,
    output logic             wd_err
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam int WD_LIMIT = PKT_LEN * CE_DIV + 16;

    logic [1:0] state;
    logic       next_rd;
    // bank_full marks FULL or READING; bank_rd marks READING only
    logic [1:0] bank_rd;

    logic rel;
    logic wd_fire;
    logic other_free;
    logic launch;
    logic wr_acc;

`ifdef SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT);
    logic [WD_W-1:0] wd_cnt;

    assign wd_fire = (state == S_BUSY) && !rd_done
                   && (wd_cnt == WD_W'(WD_LIMIT - 1));
`else
    logic unused_wd_cfg;

    assign unused_wd_cfg = (WD_LIMIT == 0);
    assign wd_fire = 1'b0;
`endif

    assign rel    = (state == S_BUSY) && (rd_done || wd_fire);
    assign launch = (state == S_IDLE) && bank_full[next_rd]
                  && !bank_rd[next_rd];
    assign wr_acc = wr_done && !wr_stall;

    // a bank released this cycle is already free for the writer
    assign other_free = !bank_full[~wr_bank]
                      || (rel && (rd_bank == ~wr_bank));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            next_rd   <= 1'b0;
            bank_rd   <= 2'b00;
            bank_full <= 2'b00;
            wr_bank   <= 1'b0;
            wr_stall  <= 1'b0;
            rd_start  <= 1'b0;
            rd_bank   <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            pkt_cnt   <= '0;
        end else begin
            rd_start <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (launch) begin
                        rd_start         <= 1'b1;
                        rd_bank          <= next_rd;
                        bank_rd[next_rd] <= 1'b1;
                        busy             <= 1'b1;
                        next_rd          <= ~next_rd;
                        state            <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (rel) begin
                        bank_full[rd_bank] <= 1'b0;
                        bank_rd[rd_bank]   <= 1'b0;
                        busy               <= 1'b0;
                        state              <= S_GAP;
                        if (rd_done) begin
                            pkt_cnt <= pkt_cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (wr_stall) begin
                if (rel) begin
                    wr_stall <= 1'b0;
                    wr_bank  <= rd_bank;
                end
                if (wr_done) begin
                    overflow <= 1'b1;
                end
            end else if (wr_acc) begin
                bank_full[wr_bank] <= 1'b1;
                if (other_free) begin
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_stall <= 1'b1;
                end
            end
        end
    end

`ifdef SCHED_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else begin
            if (launch) begin
                wd_cnt <= '0;
            end else if (state == S_BUSY) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_fire) begin
                wd_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pp_bank_scheduler.sv
// Directed testbench for pp_bank_scheduler.
// Counter width is reduced so the wrap is reachable in a short stream.
module tb_pp_bank_scheduler;

    localparam int TB_CNT_W = 8;
    localparam int N_PKT    = 300;

    logic                clk;
    logic                reset;
    logic                wr_done;
    logic                wr_bank;
    logic                wr_stall;
    logic                rd_start;
    logic                rd_bank;
    logic                rd_done;
    logic [1:0]          bank_full;
    logic                busy;
    logic                overflow;
    logic [TB_CNT_W-1:0] pkt_cnt;
`ifdef SCHED_WATCHDOG_EN
    logic                wd_err;
`endif

    int errors = 0;
    int checks = 0;

    pp_bank_scheduler #(
        .PKT_LEN (188),
        .CE_DIV  (8),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_done   (wr_done),
        .wr_bank   (wr_bank),
        .wr_stall  (wr_stall),
        .rd_start  (rd_start),
        .rd_bank   (rd_bank),
        .rd_done   (rd_done),
        .bank_full (bank_full),
        .busy      (busy),
        .overflow  (overflow),
        .pkt_cnt   (pkt_cnt)
`ifdef SCHED_WATCHDOG_EN
        ,
        .wd_err    (wd_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset   = 1'b1;
        wr_done = 1'b0;
        rd_done = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic pulse_wr;
        wr_done = 1'b1;
        tick;
        wr_done = 1'b0;
    endtask

    task automatic pulse_rd;
        rd_done = 1'b1;
        tick;
        rd_done = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        reset   = 1'b1;
        wr_done = 1'b0;
        rd_done = 1'b0;
        tick;
        v = {wr_bank, wr_stall, rd_start, rd_bank,
             bank_full, busy, overflow};
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL reset_outs: got %b want 00000000", v);
        end
        checks++;
        if (pkt_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d want 0", pkt_cnt);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_first_write;
        do_reset;
        repeat (3) tick;
        pulse_wr;
        checks++;
        if (bank_full !== 2'b01) begin
            errors++;
            $display("FAIL first_full: got %b want 01", bank_full);
        end
        checks++;
        if (wr_bank !== 1'b1) begin
            errors++;
            $display("FAIL first_wrbank: got %b want 1", wr_bank);
        end
        checks++;
        if (rd_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL first_early: start=%b busy=%b want 0 0",
                     rd_start, busy);
        end
        tick;
        checks++;
        if (rd_start !== 1'b1 || rd_bank !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_start: start=%b bank=%b busy=%b want 1 0 1",
                     rd_start, rd_bank, busy);
        end
        tick;
        checks++;
        if (rd_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_pulse: start=%b busy=%b want 0 1",
                     rd_start, busy);
        end
    endtask

    task automatic test_stall_overflow;
        do_reset;
        tick;
        pulse_wr;
        repeat (4) tick;
        pulse_wr;
        checks++;
        if (wr_stall !== 1'b1 || bank_full !== 2'b11 || wr_bank !== 1'b1) begin
            errors++;
            $display("FAIL stall: stall=%b full=%b wrb=%b want 1 11 1",
                     wr_stall, bank_full, wr_bank);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL stall_noovf: got %b want 0", overflow);
        end
        repeat (4) tick;
        pulse_wr;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow: got %b want 1", overflow);
        end
        checks++;
        if (bank_full !== 2'b11 || wr_stall !== 1'b1 || wr_bank !== 1'b1) begin
            errors++;
            $display("FAIL ovf_state: full=%b stall=%b wrb=%b want 11 1 1",
                     bank_full, wr_stall, wr_bank);
        end
    endtask

    task automatic test_stall_release;
        pulse_rd;
        checks++;
        if (bank_full !== 2'b10 || wr_bank !== 1'b0 || wr_stall !== 1'b0) begin
            errors++;
            $display("FAIL release: full=%b wrb=%b stall=%b want 10 0 0",
                     bank_full, wr_bank, wr_stall);
        end
        checks++;
        if (pkt_cnt !== 8'd1 || busy !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL release_cnt: cnt=%0d busy=%b ovf=%b want 1 0 1",
                     pkt_cnt, busy, overflow);
        end
        tick;
        checks++;
        if (rd_start !== 1'b0) begin
            errors++;
            $display("FAIL release_gap: start=%b want 0", rd_start);
        end
        tick;
        checks++;
        if (rd_start !== 1'b1 || rd_bank !== 1'b1) begin
            errors++;
            $display("FAIL release_next: start=%b bank=%b want 1 1",
                     rd_start, rd_bank);
        end
    endtask

    task automatic test_same_cycle;
        do_reset;
        pulse_wr;
        tick;
        wr_done = 1'b1;
        rd_done = 1'b1;
        tick;
        wr_done = 1'b0;
        rd_done = 1'b0;
        checks++;
        if (wr_stall !== 1'b0 || overflow !== 1'b0 || wr_bank !== 1'b0) begin
            errors++;
            $display("FAIL same: stall=%b ovf=%b wrb=%b want 0 0 0",
                     wr_stall, overflow, wr_bank);
        end
        checks++;
        if (bank_full !== 2'b10 || pkt_cnt !== 8'd1) begin
            errors++;
            $display("FAIL same_state: full=%b cnt=%0d want 10 1",
                     bank_full, pkt_cnt);
        end
        pulse_rd;
        checks++;
        if (pkt_cnt !== 8'd1 || rd_start !== 1'b0) begin
            errors++;
            $display("FAIL gap_spurious: cnt=%0d start=%b want 1 0",
                     pkt_cnt, rd_start);
        end
        tick;
        checks++;
        if (rd_start !== 1'b1 || rd_bank !== 1'b1 || bank_full !== 2'b10) begin
            errors++;
            $display("FAIL same_next: start=%b bank=%b full=%b want 1 1 10",
                     rd_start, rd_bank, bank_full);
        end
    endtask

    task automatic test_spurious_idle;
        do_reset;
        pulse_rd;
        tick;
        checks++;
        if (pkt_cnt !== 8'd0 || busy !== 1'b0 || bank_full !== 2'b00) begin
            errors++;
            $display("FAIL idle_spurious: cnt=%0d busy=%b full=%b want 0 0 00",
                     pkt_cnt, busy, bank_full);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] v;
        do_reset;
        pulse_wr;
        tick;
        tick;
        #2;
        reset = 1'b1;
        #1;
        v = {wr_bank, wr_stall, rd_start, rd_bank,
             bank_full, busy, overflow};
        checks++;
        if (v !== 8'h00 || pkt_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid: outs=%b cnt=%0d want 00000000 0",
                     v, pkt_cnt);
        end
        tick;
        reset = 1'b0;
        tick;
        pulse_rd;
        checks++;
        if (pkt_cnt !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_rd: cnt=%0d busy=%b want 0 0",
                     pkt_cnt, busy);
        end
        pulse_wr;
        checks++;
        if (bank_full !== 2'b01 || wr_bank !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_wr: full=%b wrb=%b want 01 1",
                     bank_full, wr_bank);
        end
    endtask

    task automatic test_stream;
        logic exp_bank;
        int   k;
        do_reset;
        exp_bank = 1'b0;
        for (int i = 0; i < N_PKT; i++) begin
            pulse_wr;
            k = 0;
            while (rd_start !== 1'b1 && k < 8) begin
                tick;
                k++;
            end
            checks++;
            if (rd_start !== 1'b1) begin
                errors++;
                $display("FAIL stream_timeout: pkt %0d no rd_start", i);
                break;
            end
            checks++;
            if (rd_bank !== exp_bank) begin
                errors++;
                $display("FAIL stream_bank: pkt %0d got %b want %b",
                         i, rd_bank, exp_bank);
            end
            exp_bank = ~exp_bank;
            pulse_rd;
        end
        checks++;
        if (pkt_cnt !== 8'(N_PKT % 256)) begin
            errors++;
            $display("FAIL stream_cnt: got %0d want %0d",
                     pkt_cnt, N_PKT % 256);
        end
        checks++;
        if (overflow !== 1'b0 || wr_stall !== 1'b0) begin
            errors++;
            $display("FAIL stream_flags: ovf=%b stall=%b want 0 0",
                     overflow, wr_stall);
        end
    endtask

`ifdef SCHED_WATCHDOG_EN
    task automatic test_watchdog;
        int n;
        do_reset;
        pulse_wr;
        tick;
        checks++;
        if (rd_start !== 1'b1 || wd_err !== 1'b0) begin
            errors++;
            $display("FAIL wd_start: start=%b wd=%b want 1 0",
                     rd_start, wd_err);
        end
        n = 0;
        while (wd_err !== 1'b1 && n < 1600) begin
            tick;
            n++;
        end
        checks++;
        if (n !== 1520) begin
            errors++;
            $display("FAIL wd_time: got %0d want 1520", n);
        end
        checks++;
        if (bank_full !== 2'b00 || busy !== 1'b0 || pkt_cnt !== 8'd0) begin
            errors++;
            $display("FAIL wd_state: full=%b busy=%b cnt=%0d want 00 0 0",
                     bank_full, busy, pkt_cnt);
        end
    endtask
`endif

    initial begin
        reset   = 1'b1;
        wr_done = 1'b0;
        rd_done = 1'b0;
        test_reset;
        test_first_write;
        test_stall_overflow;
        test_stall_release;
        test_same_cycle;
        test_spurious_idle;
        test_reset_mid;
        test_stream;
`ifdef SCHED_WATCHDOG_EN
        test_watchdog;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
